vga_layer_mixer: RTL
====================

Name: vga_layer_mixer

Overview:
- Downstream of the full-screen and sprite display blocks (color + is_display pairs) and the VGA scan controller.
- Each cycle, picks the highest-priority active layer (or the background), aligns sync signals to the pipeline, and converts RGB565 to 12-bit VGA.
- Applies a frame-stepped fade-out/fade-in brightness ramp for screen transitions (e.g. game screen to acknowledge screen).

Parameters:
- NUM_LAYERS, 4, number of layer inputs; layer 0 has highest priority.
- FADE_DIV, 2, frames per brightness step (1..255).
- SYNC_IDLE, 1, reset and idle value of hs/vs outputs (sync is active-low).

Ports:
- clk  in  1  pixel clock, same clock as the display blocks.
- rst  in  1  synchronous, active-high reset.
- hs_in  in  1  hsync from the scan controller, same cycle as x/y.
- vs_in  in  1  vsync from the scan controller, same cycle as x/y.
- video_on_in  in  1  visible-area flag, same cycle as x/y.
- layer_color  in  16*NUM_LAYERS  RGB565 per layer; layer i is [16i+15:16i]; registered by its source, valid one cycle after x/y.
- layer_disp  in  NUM_LAYERS  is_display per layer; combinational from x/y, so valid in the same cycle as x/y.
- bg_color  in  16  RGB565 used when no layer is active.
- fade_out_req  in  1  single-cycle pulse requesting a fade-out.
- fade_in_req  in  1  single-cycle pulse requesting a fade-in.
- r, g, b  out  4 each  VGA colour output.
- hs, vs  out  1 each  hsync/vsync delayed to match r/g/b.
- fade_busy  out  1  high while in FADE_OUT or FADE_IN.
- fade_done  out  1  one-cycle pulse when a fade completes.
- level  out  5  current brightness, 0..16.

Behaviour:
- Reset values: r/g/b=0, hs/vs=SYNC_IDLE, all pipeline valid/video_on bits=0, state=VISIBLE, level=16, fade_done=0, fade_busy=0, frame-divider count=0.
- Stage A (t+1): register layer_disp, hs_in, vs_in and video_on_in, so they align with layer_color.
- Stage B (t+2): register the selected colour.
  - Selection uses the registered layer_disp and the live layer_color.
  - Lowest-index active layer wins; if none is active, bg_color is used.
- Stage C (t+3): output stage.
  - Channel extraction: R=c[15:12], G=c[10:7], B=c[4:1].
  - Each channel out = (ch*level)>>4, using 4b×5b→9b arithmetic then truncation; level=16 gives ch unchanged.
  - If the delayed video_on=0, r/g/b=0.
- Latency from x/y to r/g/b/hs/vs is exactly 3 cycles; hs/vs pass through 3 registers unmodified.
- Frame tick: one-cycle pulse on each 0→1 transition of the stage-A vs. level changes only on a frame tick, so it is constant within a frame.
- Fade FSM states:
  - VISIBLE (level=16).
    - fade_out_req → FADE_OUT, divider count=0.
    - fade_in_req is ignored.
  - FADE_OUT: on each frame tick, count++. When count reaches FADE_DIV-1, count=0 and level−1. When level becomes 0 → BLACK, with fade_done pulsed in that cycle.
  - BLACK (level=0).
    - fade_in_req → FADE_IN, count=0.
    - fade_out_req is ignored.
  - FADE_IN: mirror of FADE_OUT, with level+1 up to 16 → VISIBLE, with fade_done pulsed.
- All requests are ignored while fade_busy=1; there is no reversal mid-fade.
- If both requests arrive in the same cycle, fade_out_req has priority; only one is ever acceptable in a given state.
- A full fade takes 16*FADE_DIV frame ticks.
- Reset mid-fade: the next cycle shows VISIBLE, level=16 and blanked outputs, with no fade_done pulse.
- A width-0 layer_disp (NUM_LAYERS≥1 is required) is not supported.

Test Plan:
- Priority, output mapping and latency:
  - Stimulus: layer_disp=4'b0110 at cycle t, layer_color[1]=16'hF800 and layer_color[2]=16'h07E0 at t+1, video_on_in=1.
  - Required: at t+3, r=4'hF, g=0, b=0.
- Background and blanking:
  - Stimulus: layer_disp=0, bg_color=16'hFFFF, video_on_in=1.
  - Required: r=g=b=4'hF three cycles later.
  - Stimulus: same, but video_on_in=0.
  - Required: r=g=b=0.
- Sync alignment:
  - Stimulus: hs_in low pulse of 96 cycles.
  - Required: hs low for exactly 96 cycles, delayed by 3 cycles; vs alignment checked the same way.
- Fade-out timing:
  - Stimulus: FADE_DIV=2, layer colour 16'hFFFF, fade_out_req pulsed, then 32 vs rising edges.
  - Required: level steps 16→15 after the 2nd tick, reaches 0 on the 32nd tick, fade_done pulses once, r=0 afterwards.
  - Stimulus: at level=8.
  - Required: r=4'h7.
- Request filtering:
  - Stimulus: fade_in_req in VISIBLE.
  - Required: no state change.
  - Stimulus: fade_in_req and fade_out_req in the same cycle while VISIBLE.
  - Required: FADE_OUT.
  - Stimulus: fade_in_req during FADE_OUT.
  - Required: ignored; the fade runs to BLACK.
- Reset mid-fade:
  - Stimulus: rst asserted at level=5 during FADE_IN.
  - Required: next cycle level=16, fade_busy=0, hs=vs=1, r/g/b=0; no fade_done pulse.

Source files
------------

// File: rtl/vga_layer_mixer.sv
// Layer priority mixer for the VGA path: picks the top active layer, aligns sync to the
// three-stage pipeline, converts RGB565 to 12-bit VGA and applies a frame-stepped fade ramp.
module vga_layer_mixer #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned FADE_DIV   = 2,
  parameter bit          SYNC_IDLE  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hs_in,
  input  logic                    vs_in,
  input  logic                    video_on_in,
  input  logic [16*NUM_LAYERS-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]   layer_disp,
  input  logic [15:0]             bg_color,
  input  logic                    fade_out_req,
  input  logic                    fade_in_req,
  output logic [3:0]              r,
  output logic [3:0]              g,
  output logic [3:0]              b,
  output logic                    hs,
  output logic                    vs,
  output logic                    fade_busy,
  output logic                    fade_done,
  output logic [4:0]              level
);

  localparam logic [7:0] DivLast = 8'(FADE_DIV - 1);

  typedef enum logic [1:0] {StVisible, StFadeOut, StBlack, StFadeIn} state_e;

  // Stage A: control signals delayed one cycle to line up with the registered layer colours.
  logic [NUM_LAYERS-1:0] disp_a;
  logic                  hs_a, vs_a, von_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_a <= '0;
      hs_a   <= SYNC_IDLE;
      vs_a   <= SYNC_IDLE;
      von_a  <= 1'b0;
    end else begin
      disp_a <= layer_disp;
      hs_a   <= hs_in;
      vs_a   <= vs_in;
      von_a  <= video_on_in;
    end
  end

  // Scan from the lowest priority upwards so the lowest active index is the last to win.
  logic [15:0] sel_color;

  always_comb begin
    sel_color = bg_color;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (disp_a[i]) begin
        sel_color = layer_color[16*i +: 16];
      end
    end
  end

  // Stage B
  logic [15:0] color_b;
  logic        hs_b, vs_b, von_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      color_b <= '0;
      hs_b    <= SYNC_IDLE;
      vs_b    <= SYNC_IDLE;
      von_b   <= 1'b0;
    end else begin
      color_b <= sel_color;
      hs_b    <= hs_a;
      vs_b    <= vs_a;
      von_b   <= von_a;
    end
  end

  // RGB565 low bits are dropped when narrowing to 4 bits per channel.
  logic unused_color_bits;
  assign unused_color_bits = ^{color_b[11], color_b[6:5], color_b[0]};

  function automatic logic [3:0] scale(input logic [3:0] ch, input logic [4:0] lv);
    logic [8:0] prod;
    prod = {5'b0, ch} * {4'b0, lv};
    return 4'(prod >> 4);
  endfunction

  // Stage C
  always_ff @(posedge clk) begin
    if (rst) begin
      r  <= '0;
      g  <= '0;
      b  <= '0;
      hs <= SYNC_IDLE;
      vs <= SYNC_IDLE;
    end else begin
      hs <= hs_b;
      vs <= vs_b;
      if (von_b) begin
        r <= scale(color_b[15:12], level);
        g <= scale(color_b[10:7], level);
        b <= scale(color_b[4:1], level);
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
    end
  end

  // Rising edge of the stage-A vsync; stage B holds the previous stage-A value.
  logic frame_tick;
  assign frame_tick = vs_a & ~vs_b;

  state_e     state_q;
  logic [7:0] div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StVisible;
      level     <= 5'd16;
      div_q     <= '0;
      fade_done <= 1'b0;
      fade_busy <= 1'b0;
    end else begin
      fade_done <= 1'b0;
      case (state_q)
        StVisible: begin
          if (fade_out_req) begin
            state_q   <= StFadeOut;
            div_q     <= '0;
            fade_busy <= 1'b1;
          end
        end
        StBlack: begin
          if (fade_in_req) begin
            state_q   <= StFadeIn;
            div_q     <= '0;
            fade_busy <= 1'b1;
          end
        end
        StFadeOut: begin
          if (frame_tick) begin
            if (div_q == DivLast) begin
              div_q <= '0;
              level <= level - 5'd1;
              if (level == 5'd1) begin
                state_q   <= StBlack;
                fade_busy <= 1'b0;
                fade_done <= 1'b1;
              end
            end else begin
              div_q <= div_q + 8'd1;
            end
          end
        end
        StFadeIn: begin
          if (frame_tick) begin
            if (div_q == DivLast) begin
              div_q <= '0;
              level <= level + 5'd1;
              if (level == 5'd15) begin
                state_q   <= StVisible;
                fade_busy <= 1'b0;
                fade_done <= 1'b1;
              end
            end else begin
              div_q <= div_q + 8'd1;
            end
          end
        end
        default: state_q <= StVisible;
      endcase
    end
  end

endmodule
